// File: rtl/match_scorer.sv
// match_scorer: grades serialized match timing errors and keeps score, combo and multiplier.
// Optional max-combo tracking is built when MATCH_SCORER_MAX_COMBO_EN is defined.
module match_scorer #(
    parameter logic [15:0] PERFECT_WIN = 16'd20,
    parameter logic [15:0] GOOD_WIN    = 16'd50,
    parameter logic [15:0] OK_WIN      = 16'd100,
    parameter logic [7:0]  PTS_PERFECT = 8'd50,
    parameter logic [7:0]  PTS_GOOD    = 8'd30,
    parameter logic [7:0]  PTS_OK      = 8'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        match_en,
    input  logic [15:0] match_dt,
    input  logic        miss_en,
    output logic [23:0] score,
    output logic [9:0]  combo,
    output logic [2:0]  multiplier,
    output logic [1:0]  grade,
    output logic        grade_valid,
    output logic [9:0]  max_combo
);

    typedef enum logic [1:0] {
        GR_MISS    = 2'd0,
        GR_OK      = 2'd1,
        GR_GOOD    = 2'd2,
        GR_PERFECT = 2'd3
    } grade_t;

    function automatic grade_t classify(input logic [15:0] a);
        if (a <= PERFECT_WIN)   return GR_PERFECT;
        else if (a <= GOOD_WIN) return GR_GOOD;
        else if (a <= OK_WIN)   return GR_OK;
        else                    return GR_MISS;
    endfunction

    logic [15:0] abs_in;
    logic [15:0] abs_dt;
    logic        s1_hit_v;
    logic        s1_miss_v;
    grade_t      cls_grade;
    logic        hit_v;
    logic        miss_v;

    logic        hit;
    logic [7:0]  base_pts;
    logic [10:0] product;
    logic [24:0] sum;
    logic [23:0] score_next;
    logic [9:0]  combo_next;

    // -32768 has no positive counterpart in 16 bits, so it clamps to 32767.
    always_comb begin
        abs_in = match_dt;
        if (match_dt[15]) begin
            abs_in = (match_dt == 16'h8000) ? 16'h7FFF : 16'(-match_dt);
        end
    end

    always_comb begin
        if (combo >= 10'd30)      multiplier = 3'd4;
        else if (combo >= 10'd20) multiplier = 3'd3;
        else if (combo >= 10'd10) multiplier = 3'd2;
        else                      multiplier = 3'd1;
    end

    always_comb begin
        hit        = hit_v && (cls_grade != GR_MISS);
        base_pts   = 8'd0;
        case (cls_grade)
            GR_PERFECT: base_pts = PTS_PERFECT;
            GR_GOOD:    base_pts = PTS_GOOD;
            GR_OK:      base_pts = PTS_OK;
            default:    base_pts = 8'd0;
        endcase
        product    = 11'(base_pts) * 11'(multiplier);
        sum        = {1'b0, score} + 25'(product);
        score_next = score;
        combo_next = combo;
        if (hit) begin
            score_next = sum[24] ? '1 : sum[23:0];
            combo_next = (combo == 10'd1023) ? combo : combo + 10'd1;
        end
        // A simultaneous miss still lets the hit score, then breaks the combo.
        if ((hit_v && !hit) || miss_v) begin
            combo_next = '0;
        end
    end

    // Three register layers: capture |dt|, register grade and strobes, accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abs_dt      <= '0;
            s1_hit_v    <= 1'b0;
            s1_miss_v   <= 1'b0;
            cls_grade   <= GR_MISS;
            hit_v       <= 1'b0;
            miss_v      <= 1'b0;
            score       <= '0;
            combo       <= '0;
            grade       <= '0;
            grade_valid <= 1'b0;
        end else begin
            abs_dt      <= abs_in;
            s1_hit_v    <= match_en;
            s1_miss_v   <= miss_en;
            cls_grade   <= classify(abs_dt);
            hit_v       <= s1_hit_v;
            miss_v      <= s1_miss_v;
            score       <= score_next;
            combo       <= combo_next;
            grade_valid <= hit_v || miss_v;
            if (hit_v) begin
                grade <= cls_grade;
            end else if (miss_v) begin
                grade <= GR_MISS;
            end
        end
    end

`ifdef MATCH_SCORER_MAX_COMBO_EN
    logic [9:0] max_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (combo_next > max_q) begin
            max_q <= combo_next;
        end
    end

    assign max_combo = max_q;
`else
    assign max_combo = 10'd0;
`endif

endmodule

// File: tb/tb_match_scorer.sv
// Self-checking bench for match_scorer: per-cycle reference model plus a saturation run
// on a second instance with enlarged PERFECT points.
module tb_match_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        match_en = 1'b0;
    logic [15:0] match_dt = '0;
    logic        miss_en = 1'b0;
    logic [23:0] score;
    logic [9:0]  combo;
    logic [2:0]  multiplier;
    logic [1:0]  grade;
    logic        grade_valid;
    logic [9:0]  max_combo;

    logic        sat_en = 1'b0;
    logic [23:0] sat_score;
    logic [9:0]  sat_combo;
    logic [2:0]  sat_mult;
    logic [1:0]  sat_grade;
    logic        sat_gv;
    logic [9:0]  sat_max;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    match_scorer dut (
        .clk(clk), .rst_n(rst_n), .match_en(match_en), .match_dt(match_dt),
        .miss_en(miss_en), .score(score), .combo(combo), .multiplier(multiplier),
        .grade(grade), .grade_valid(grade_valid), .max_combo(max_combo)
    );

    match_scorer #(.PTS_PERFECT(8'd250)) dut_sat (
        .clk(clk), .rst_n(rst_n), .match_en(sat_en), .match_dt(16'd0),
        .miss_en(1'b0), .score(sat_score), .combo(sat_combo), .multiplier(sat_mult),
        .grade(sat_grade), .grade_valid(sat_gv), .max_combo(sat_max)
    );

    typedef struct packed {
        logic [23:0] score;
        logic [9:0]  combo;
        logic [2:0]  mult;
        logic [1:0]  grade;
        logic        gv;
        logic [9:0]  maxc;
    } snap_t;

    snap_t obs  [4096];
    snap_t want [4096];
    int    t = 0;

    int       m_score, m_combo, m_max;
    logic [1:0] m_grade;

    localparam snap_t RST_SNAP = '{score: 24'd0, combo: 10'd0, mult: 3'd1, grade: 2'd0, gv: 1'b0, maxc: 10'd0};

    function automatic int pts(input int g);
        case (g)
            3: return 50;
            2: return 30;
            1: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int mult_of(input int c);
        return (c / 10 + 1 > 4) ? 4 : c / 10 + 1;
    endfunction

    // Records what the DUT shows now, drives one input cycle, and predicts its effect 3 slots on.
    task automatic step(input logic en, input logic [15:0] dt, input logic ms);
        int d, a, g;
        logic gv;
        @(negedge clk);
        obs[t] = {score, combo, multiplier, grade, grade_valid, max_combo};
        match_en = en;
        match_dt = dt;
        miss_en  = ms;
        d = int'($signed(dt));
        a = (d < 0) ? -d : d;
        if (a > 32767) a = 32767;
        g = (a <= 20) ? 3 : (a <= 50) ? 2 : (a <= 100) ? 1 : 0;
        gv = 1'b0;
        if (en) begin
            if (g != 0) begin
                m_score = m_score + pts(g) * mult_of(m_combo);
                if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
                m_combo = (m_combo == 1023) ? 1023 : m_combo + 1;
            end else begin
                m_combo = 0;
            end
            m_grade = 2'(g);
            gv = 1'b1;
        end
        if (ms) begin
            m_combo = 0;
            if (!en) m_grade = 2'd0;
            gv = 1'b1;
        end
`ifdef MATCH_SCORER_MAX_COMBO_EN
        if (m_combo > m_max) m_max = m_combo;
`else
        m_max = 0;
`endif
        want[t + 3] = {24'(m_score), 10'(m_combo), 3'(mult_of(m_combo)), m_grade, gv, 10'(m_max)};
        t++;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int unsigned hold);
        @(negedge clk);
        rst_n = 1'b0;
        match_en = 1'b0;
        miss_en = 1'b0;
        sat_en = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        m_score = 0;
        m_combo = 0;
        m_max = 0;
        m_grade = 2'd0;
        for (int j = 0; j < 3; j++) want[t + j] = RST_SNAP;
    endtask

    task automatic test_reset;
        int t0;
        do_reset(3);
        t0 = t;
        idle(4);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL reset_state slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
    endtask

    task automatic test_first_perfect;
        int t0;
        do_reset(2);
        t0 = t;
        step(1'b1, 16'd15, 1'b0);
        idle(4);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL first_perfect slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
        tests_run++;
        if (score !== 24'd50 || combo !== 10'd1 || multiplier !== 3'd1 || grade !== 2'd3) begin
            tests_failed++;
            $display("FAIL first_perfect_final: got score=%0d combo=%0d mult=%0d grade=%0d need 50 1 1 3",
                     score, combo, multiplier, grade);
        end
    endtask

    task automatic test_grades;
        int t0;
        do_reset(2);
        t0 = t;
        step(1'b1, 16'hFFD8, 1'b0);  // -40
        step(1'b1, 16'd100, 1'b0);
        step(1'b1, 16'd101, 1'b0);
        idle(4);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL grades slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
        tests_run++;
        if (score !== 24'd40 || combo !== 10'd0 || grade !== 2'd0) begin
            tests_failed++;
            $display("FAIL grades_final: got score=%0d combo=%0d grade=%0d need 40 0 0", score, combo, grade);
        end
    endtask

    task automatic test_windows;
        int t0;
        logic [15:0] edges [10];
        edges = '{16'd20, 16'hFFEC, 16'd21, 16'hFFEB, 16'd50, 16'hFFCE, 16'd51, 16'hFF9C, 16'hFF9B, 16'h7FFF};
        do_reset(2);
        t0 = t;
        foreach (edges[i]) begin
            step(1'b1, edges[i], 1'b0);
            idle(1);
        end
        idle(3);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL windows slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
    endtask

    task automatic test_multiplier;
        int t0;
        do_reset(2);
        t0 = t;
        for (int i = 0; i < 12; i++) step(1'b1, 16'd0, 1'b0);
        idle(3);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL multiplier slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
        tests_run++;
`ifdef MATCH_SCORER_MAX_COMBO_EN
        if (score !== 24'd700 || combo !== 10'd12 || multiplier !== 3'd2 || max_combo !== 10'd12) begin
`else
        if (score !== 24'd700 || combo !== 10'd12 || multiplier !== 3'd2 || max_combo !== 10'd0) begin
`endif
            tests_failed++;
            $display("FAIL multiplier_final: got score=%0d combo=%0d mult=%0d max=%0d", score, combo, multiplier, max_combo);
        end
    endtask

    task automatic test_back_to_back_hit_miss;
        int t0;
        do_reset(2);
        t0 = t;
        for (int i = 0; i < 26; i++) step(1'b1, 16'd5, 1'b0);
        step(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b1, 16'hFFFE, 1'b0);
        step(1'b1, 16'd0, 1'b1);
        idle(3);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL hit_miss slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
        tests_run++;
`ifdef MATCH_SCORER_MAX_COMBO_EN
        if (score !== 24'd4800 || combo !== 10'd0 || grade !== 2'd3 || max_combo !== 10'd26) begin
`else
        if (score !== 24'd4800 || combo !== 10'd0 || grade !== 2'd3 || max_combo !== 10'd0) begin
`endif
            tests_failed++;
            $display("FAIL hit_miss_final: got score=%0d combo=%0d grade=%0d max=%0d need 4800 0 3",
                     score, combo, grade, max_combo);
        end
    endtask

    task automatic test_dt_min;
        int t0;
        do_reset(2);
        t0 = t;
        for (int i = 0; i < 3; i++) step(1'b1, 16'd1, 1'b0);
        step(1'b1, 16'h8000, 1'b0);
        idle(3);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL dt_min slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
        tests_run++;
        if (combo !== 10'd0 || grade !== 2'd0 || score !== 24'd150) begin
            tests_failed++;
            $display("FAIL dt_min_final: got combo=%0d grade=%0d score=%0d need 0 0 150", combo, grade, score);
        end
    endtask

    task automatic test_random;
        int t0;
        logic [15:0] dt;
        int r;
        do_reset(2);
        t0 = t;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      dt = 16'h8000;
            else if (r == 1) dt = 16'h7FFF;
            else             dt = 16'(int'($urandom_range(0, 260)) - 130);
            step($urandom_range(0, 2) != 0, dt, $urandom_range(0, 5) == 0);
        end
        idle(3);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL random slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
    endtask

    task automatic test_reset_midstream;
        int t0;
        do_reset(2);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd3, 1'b0);
        step(1'b1, 16'd3, 1'b1);
        do_reset(1);
        t0 = t;
        idle(5);
        for (int k = t0; k < t; k++) begin
            tests_run++;
            if (obs[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL reset_midstream slot %0d: got %013h need %013h", k, obs[k], want[k]);
            end
        end
    endtask

    task automatic test_saturation;
        int s, c, n, m, exp_c;
        s = 0; c = 0; n = 0;
        forever begin
            m = mult_of(c);
            if (s + 250 * m > 24'hFFFFFF) break;
            s = s + 250 * m;
            c = (c == 1023) ? 1023 : c + 1;
            n++;
        end
        do_reset(2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sat_en = 1'b1;
        end
        @(negedge clk);
        sat_en = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (sat_score !== 24'(s)) begin
            tests_failed++;
            $display("FAIL sat_near: got score=%h need %h", sat_score, 24'(s));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sat_en = 1'b1;
        end
        @(negedge clk);
        sat_en = 1'b0;
        repeat (4) @(negedge clk);
        exp_c = (n + 3 > 1023) ? 1023 : n + 3;
        tests_run++;
        if (sat_score !== 24'hFFFFFF || sat_combo !== 10'(exp_c) || sat_mult !== 3'd4 || sat_grade !== 2'd3) begin
            tests_failed++;
            $display("FAIL sat_hold: got score=%h combo=%0d mult=%0d grade=%0d need ffffff %0d 4 3",
                     sat_score, sat_combo, sat_mult, sat_grade, exp_c);
        end
        tests_run++;
`ifdef MATCH_SCORER_MAX_COMBO_EN
        if (sat_max !== 10'(exp_c)) begin
`else
        if (sat_max !== 10'd0) begin
`endif
            tests_failed++;
            $display("FAIL sat_max_combo: got %0d", sat_max);
        end
    endtask

    initial begin
        test_reset;
        test_first_perfect;
        test_grades;
        test_windows;
        test_multiplier;
        test_back_to_back_hit_miss;
        test_dt_min;
        test_random;
        test_reset_midstream;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
